// File: rtl/kyogenrv_pio_ext.sv
// KyogenRV extended PIO: data/direction registers, synchronised inputs,
// per-bit edge capture with masked level interrupt and set/clear aliases.
module kyogenrv_pio_ext #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_IRQMASK = 3'd2;
    localparam logic [2:0] A_EDGECAP = 3'd3;
    localparam logic [2:0] A_OUTSET  = 3'd4;
    localparam logic [2:0] A_OUTCLR  = 3'd5;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             wr;

    assign wr = chipselect && !write_n;
    assign wd = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    generate
        if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~sync2 & prev;
        end else if (EDGE_TYPE == 2) begin : g_any
            assign edge_det = sync2 ^ prev;
        end else begin : g_rise
            assign edge_det = sync2 & ~prev;
        end
    endgenerate

    assign cap_clr = (wr && address == A_EDGECAP) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            dir      <= DIR_RESET;
            irqmask  <= '0;
        end else if (wr) begin
            case (address)
                A_DATA:    data_out <= wd;
                A_DIR:     dir      <= wd;
                A_IRQMASK: irqmask  <= wd;
                A_OUTSET:  data_out <= data_out | wd;
                A_OUTCLR:  data_out <= data_out & ~wd;
                default:   ;
            endcase
        end
    end

    // A new detection overrides a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clr) | edge_det;
        end
    end

    always_comb begin
        rd = '0;
        case (address)
            A_DATA:    rd = (dir & data_out) | (~dir & sync2);
            A_DIR:     rd = dir;
            A_IRQMASK: rd = irqmask;
            A_EDGECAP: rd = edgecap;
            default:   rd = '0;
        endcase
    end

    always_comb begin
        readdata            = '0;
        readdata[WIDTH-1:0] = rd;
    end

    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_kyogenrv_pio_ext.sv
// Directed scoreboard bench for kyogenrv_pio_ext (WIDTH=8, rising edges).
module tb_kyogenrv_pio_ext;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    kyogenrv_pio_ext #(
        .WIDTH(8),
        .RESET_VALUE(8'hA5),
        .DIR_RESET(8'h0F),
        .EDGE_TYPE(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .out_port(out_port),
        .oe(oe),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kinds: 0 readdata, 1 out_port, 2 oe, 3 irq
    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          n_vec;
    int          n_bad;

    initial begin
        n_vec = 0;
        n_bad = 0;
    end

    // Monitor: all expectations queued during a high phase are checked
    // at the following falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                logic [31:0] e;
                logic [31:0] a;
                int          k;
                string       n;
                e = exp_q.pop_front();
                k = kind_q.pop_front();
                n = name_q.pop_front();
                case (k)
                    0:       a = readdata;
                    1:       a = {24'h0, out_port};
                    2:       a = {24'h0, oe};
                    default: a = {31'h0, irq};
                endcase
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
                end
            end
        end
    end

    task automatic expect_val(input int k, input string n,
                              input logic [31:0] e);
        exp_q.push_back(e);
        kind_q.push_back(k);
        name_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e,
                      input string n);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        expect_val(0, n, e);
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        expect_val(1, "rst_out_port", 32'hA5);
        expect_val(2, "rst_oe", 32'h0F);
        expect_val(3, "rst_irq", 32'h0);
        rd(3'd1, 32'h0F, "rst_dir");
        rd(3'd2, 32'h00, "rst_irqmask");
        rd(3'd3, 32'h00, "rst_edgecap");
        rd(3'd6, 32'h00, "rst_reserved6");
        rd(3'd0, 32'h05, "rst_data");
        rd(3'd4, 32'h00, "outset_reads0");

        wr(3'd0, 32'h3C);
        wr(3'd4, 32'h81);
        expect_val(1, "outset", 32'hBD);
        tick();
        wr(3'd5, 32'h0C);
        expect_val(1, "outclr", 32'hB1);
        tick();
        wr(3'd0, 32'h1FF);
        expect_val(1, "data_wide", 32'hFF);
        rd(3'd0, 32'h0F, "data_read_wide");

        wr(3'd1, 32'h0F);
        wr(3'd0, 32'h05);
        in_port = 8'hA0;
        tick();
        tick();
        rd(3'd0, 32'hA5, "data_mixed");
        wr(3'd3, 32'hFF);
        rd(3'd3, 32'h00, "edgecap_cleared");

        wr(3'd2, 32'h10);
        rd(3'd2, 32'h10, "irqmask_rb");
        in_port = 8'hB0;
        tick();
        tick();
        tick();
        expect_val(3, "irq_rise", 32'h1);
        rd(3'd3, 32'h10, "edgecap_bit4");
        wr(3'd3, 32'h10);
        expect_val(3, "irq_cleared", 32'h0);
        rd(3'd3, 32'h00, "edgecap_w1c");

        in_port = 8'hA0;
        repeat (4) tick();
        rd(3'd3, 32'h00, "fall_no_cap");
        expect_val(3, "fall_no_irq", 32'h0);
        tick();

        in_port = 8'hB0;
        tick();
        tick();
        wr(3'd3, 32'h10);
        rd(3'd3, 32'h10, "detect_beats_clr");
        expect_val(3, "detect_irq", 32'h1);
        tick();

        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'hFF;
        repeat (4) tick();
        wr(3'd0, 32'h00);
        expect_val(1, "pre_rst_out", 32'h00);
        expect_val(3, "pre_rst_irq", 32'h1);
        rd(3'd3, 32'hFF, "pre_rst_edgecap");

        reset_n    = 1'b0;
        address    = 3'd3;
        chipselect = 1'b1;
        expect_val(0, "async_edgecap", 32'h0);
        expect_val(1, "async_out", 32'hA5);
        expect_val(2, "async_oe", 32'h0F);
        expect_val(3, "async_irq", 32'h0);
        tick();
        chipselect = 1'b0;
        tick();

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
